// File: rtl/rv_pipe_pkg.sv
// Shared types and constants for the RV32 fetch/decode pipeline registers.
package rv_pipe_pkg;

  localparam int RV_XLEN = 32;

  // Canonical NOP: addi x0, x0, 0
  localparam logic [RV_XLEN-1:0] RV_NOP = 32'h0000_0013;

  // One fetched beat as it travels from fetch to decode
  typedef struct packed {
    logic [RV_XLEN-1:0] pc;
    logic [RV_XLEN-1:0] instr;
  } if_id_entry_t;

  // Buffer occupancy: 0, 1 or 2 beats held
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } if_id_state_t;

  // Link value for JAL/JALR; wraps modulo 2^XLEN
  function automatic logic [RV_XLEN-1:0] rv_pc_plus4(input logic [RV_XLEN-1:0] pc);
    return pc + RV_XLEN'(4);
  endfunction

endpackage

// File: rtl/if_id_perf_counter.sv
// Saturating event counter with enable and synchronous active-low reset.
module if_id_perf_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count enabled cycles, holding at all-ones instead of wrapping
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/if_id_buffer.sv
// Two-entry skid FIFO between fetch and decode.
// if_ready depends only on registered occupancy (plus reset), so decode stalls
// never form a combinational path back into fetch. Head outputs come straight
// from storage. A flush empties the buffer and drops the incoming beat.
// Optional build macro: IF_ID_PERF_EN adds stall_cnt / flush_cnt counters.
module if_id_buffer
  import rv_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_instr,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [XLEN-1:0] id_instr
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt
`endif
);

  // The pointer/state logic below is written for exactly two slots
  generate
    if (DEPTH != 2 || XLEN != RV_XLEN) begin : g_bad_param
      $error("if_id_buffer: DEPTH must be 2 and XLEN must match RV_XLEN");
    end
  endgenerate

  if_id_state_t r_state;
  if_id_state_t w_state_next;
  logic         r_wr_ptr;
  logic         r_rd_ptr;

  logic         w_push;
  logic         w_pop;
  if_id_entry_t w_in_entry;
  if_id_entry_t w_head;
  if_id_entry_t w_entry [2];

  assign if_ready   = (r_state != BUF_FULL) & rst;
  assign id_valid   = (r_state != BUF_EMPTY);
  assign w_push     = if_valid & if_ready & ~flush;
  assign w_pop      = id_valid & id_ready & ~flush;
  assign w_in_entry = '{pc: if_pc, instr: if_instr};

  // Per-slot storage: each slot is written only when it is the push target,
  // so garbage on if_* while not accepting never reaches the array
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      if_id_entry_t r_entry;

      // Capture a pushed beat into this slot; clear to 0/NOP on reset
      always_ff @(posedge clk) begin
        if (!rst) begin
          r_entry <= '{pc: '0, instr: RV_NOP};
        end else if (w_push && (r_wr_ptr == 1'(gi))) begin
          r_entry <= w_in_entry;
        end
      end

      assign w_entry[gi] = r_entry;
    end
  endgenerate

  // Next occupancy from push/pop; FULL never pushes because if_ready is low
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BUF_EMPTY: if (w_push) w_state_next = BUF_ONE;
      BUF_ONE: begin
        if (w_push && !w_pop)      w_state_next = BUF_FULL;
        else if (w_pop && !w_push) w_state_next = BUF_EMPTY;
      end
      BUF_FULL:  if (w_pop) w_state_next = BUF_ONE;
      default:   w_state_next = BUF_EMPTY;
    endcase
  end

  // Occupancy and circular pointers; flush and reset both return to empty
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      r_state  <= BUF_EMPTY;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
    end
  end

  assign w_head = w_entry[r_rd_ptr];

  // Present the head beat; an empty buffer shows PC 0 and a NOP
  always_comb begin
    id_pc    = '0;
    id_instr = RV_NOP;
    if (id_valid) begin
      id_pc    = w_head.pc;
      id_instr = w_head.instr;
    end
  end

  assign id_pc_plus4 = rv_pc_plus4(id_pc);

`ifdef IF_ID_PERF_EN
  logic w_stall_evt;
  logic w_flush_evt;

  assign w_stall_evt = id_valid & ~id_ready;
  assign w_flush_evt = flush & (r_state != BUF_EMPTY);

  if_id_perf_counter #(.WIDTH(32)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_stall_evt),
    .o_count (stall_cnt)
  );

  if_id_perf_counter #(.WIDTH(32)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_flush_evt),
    .o_count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios followed by random
// traffic, all compared against a queue-based FIFO reference model.
module tb_if_id_buffer;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_instr;
`ifdef IF_ID_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  beat_t q[$];
  int    tests;
  int    failed;
`ifdef IF_ID_PERF_EN
  int unsigned m_stall;
  int unsigned m_flush;
`endif

  if_id_buffer dut (
    .clk         (clk),
    .rst         (rst),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .flush       (flush),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_pc       (id_pc),
    .id_pc_plus4 (id_pc_plus4),
    .id_instr    (id_instr)
`ifdef IF_ID_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model at the edge, check outputs at negedge
  task automatic step(input logic r, input logic v, input logic [31:0] pc,
                      input logic [31:0] ins, input logic rd, input logic fl);
    int    n;
    bit    acc;
    beat_t b;
    rst = r; if_valid = v; if_pc = pc; if_instr = ins; id_ready = rd; flush = fl;
    @(posedge clk);
    n = q.size();
    if (!r) begin
      q.delete();
`ifdef IF_ID_PERF_EN
      m_stall = 0; m_flush = 0;
`endif
    end else begin
`ifdef IF_ID_PERF_EN
      if (n > 0 && !rd && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (fl && n > 0 && m_flush != 32'hFFFF_FFFF) m_flush++;
`endif
      if (fl) begin
        q.delete();
      end else begin
        acc = v && (n < 2);
        if (n > 0 && rd) void'(q.pop_front());
        if (acc) begin
          b.pc = pc; b.instr = ins;
          q.push_back(b);
        end
      end
    end
    @(negedge clk);
    chk("if_ready", {31'd0, if_ready}, {31'd0, (rst && q.size() < 2)});
    chk("id_valid", {31'd0, id_valid}, {31'd0, (q.size() > 0)});
    if (q.size() > 0) begin
      chk("id_pc", id_pc, q[0].pc);
      chk("id_instr", id_instr, q[0].instr);
      chk("id_pc_plus4", id_pc_plus4, q[0].pc + 32'd4);
    end else begin
      chk("id_instr_nop", id_instr, NOP);
    end
`ifdef IF_ID_PERF_EN
    chk("stall_cnt", stall_cnt, m_stall);
    chk("flush_cnt", flush_cnt, m_flush);
`endif
  endtask

  initial begin
    tests = 0; failed = 0;
`ifdef IF_ID_PERF_EN
    m_stall = 0; m_flush = 0;
`endif
    rst = 1'b0; if_valid = 1'b0; if_pc = '0; if_instr = '0; id_ready = 1'b0; flush = 1'b0;

    // 1. reset held 3 cycles with fetch offering a beat
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_pc_plus4", id_pc_plus4, 32'd4);
    chk("rst_instr", id_instr, NOP);

    // 2. streaming with decode always ready
    step(1'b1, 1'b1, 32'h0, 32'hAAAA_0001, 1'b1, 1'b0);
    chk("s_pc0", id_pc, 32'h0);
    step(1'b1, 1'b1, 32'h4, 32'hBBBB_0002, 1'b1, 1'b0);
    chk("s_pc4", id_pc, 32'h4);
    chk("s_ready", {31'd0, if_ready}, 32'd1);
    step(1'b1, 1'b1, 32'h8, 32'hCCCC_0003, 1'b1, 1'b0);
    chk("s_instr8", id_instr, 32'hCCCC_0003);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // 3. stall/skid then drain
    step(1'b1, 1'b1, 32'h10, 32'h1111_0010, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h14, 32'h1111_0014, 1'b0, 1'b0);
    chk("skid_full", {31'd0, if_ready}, 32'd0);
    step(1'b1, 1'b1, 32'h18, 32'h1111_0018, 1'b0, 1'b0);
    chk("skid_hold", id_pc, 32'h10);
    step(1'b1, 1'b1, 32'h18, 32'h1111_0018, 1'b1, 1'b0);
    chk("drain_14", id_pc, 32'h14);
    step(1'b1, 1'b1, 32'h18, 32'h1111_0018, 1'b1, 1'b0);
    chk("drain_18", id_pc, 32'h18);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // 4. flush while FULL with a beat offered
    step(1'b1, 1'b1, 32'h20, 32'h2222_0020, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h24, 32'h2222_0024, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h28, 32'h2222_0028, 1'b1, 1'b1);
    chk("flush_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_nop", id_instr, NOP);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("flush_drop", {31'd0, id_valid}, 32'd0);

    // 5. pc+4 wrap, then reset while FULL
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h3333_0001, 1'b0, 1'b0);
    chk("wrap", id_pc_plus4, 32'h0);
    step(1'b1, 1'b1, 32'h40, 32'h3333_0002, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("rst_full", {31'd0, id_valid}, 32'd0);

`ifdef IF_ID_PERF_EN
    // 6. 5 stalled cycles then one flush of a non-empty buffer
    step(1'b1, 1'b1, 32'h50, 32'h4444_0050, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    chk("perf_stall", stall_cnt, 32'd5);
    chk("perf_flush", flush_cnt, 32'd1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic        r, v, rd, fl;
      logic [31:0] pc, ins;
      r   = ($urandom_range(0, 63) != 0);
      v   = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 2) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      pc  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      ins = $urandom;
      step(r, v, pc, ins, rd, fl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
